csa_tree_pipe: RTL and testbench
================================

# csa_tree_pipe

Pipelined, parametrised carry-save reduction tree that sums NUM_OPS unsigned WIDTH-bit operands per transaction. It is built from registered levels of 4:2 compressors and has a valid/ready handshake on both sides. An optional final carry-propagate stage is compiled in with a macro. It sits in the arith library as the multi-operand reduction engine for multipliers, dot-product and popcount datapaths.

## Interface
- WIDTH, 32, bit width of each operand (≥ 2)
- NUM_OPS, 8, operand count; power of two, 4..32
- TAG_W, 4, side-band tag width carried alongside the data (≥ 1)
- Derived: LEVELS = log2(NUM_OPS) − 1; OUT_W = WIDTH + log2(NUM_OPS)

Ports:
- clk  input  1  clock; reset is synchronous and active-high
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operand vector valid
- in_ready  output  1  block accepts the vector this cycle
- in_ops  input  NUM_OPS*WIDTH  packed operands; operand k occupies bits [k*WIDTH +: WIDTH]
- in_tag  input  TAG_W  tag, returned unmodified with the result
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- out_sum  output  OUT_W  redundant sum vector
- out_carry  output  OUT_W  redundant carry vector; out_sum + out_carry mod 2^OUT_W is the total
- out_result  output  OUT_W  binary total; present only with the CPA macro
- out_tag  output  TAG_W  tag of the current result

## Operation
- Operands are zero-extended to OUT_W before reduction, so the total never overflows OUT_W.
- Level i (1..LEVELS) takes NUM_OPS/2^(i−1) vectors and produces half as many through 4:2 compressors. Carry outputs are shifted left by 1 and truncated to OUT_W. The level output is registered.
- The final level leaves exactly two vectors, which drive out_sum and out_carry.
- A valid bit and the tag travel with each pipeline stage.
- Stall uses a single global enable: en = !out_valid || out_ready. All stage registers, valid bits and tags advance only when en = 1.
- in_ready = en && !rst. Bubbles are not squeezed out.
- A transfer happens on in_valid && in_ready on the input side, and on out_valid && out_ready on the output side.
- Reset clears all valid bits, data registers and tags to 0. After reset, out_valid = 0, out_sum = out_carry = out_result = 0 and out_tag = 0.
- Reset asserted mid-operation discards all in-flight transactions. No partial result is ever presented.
- Outputs hold stable while out_valid && !out_ready.

## Timing
- Latency from input transfer to out_valid is LEVELS cycles without CPA and LEVELS+1 cycles with CPA.
- With CPA compiled in, out_sum and out_carry are also delayed one stage, so all outputs stay aligned to out_valid.
- Throughput is one transaction per cycle while out_ready = 1.
- in_ready depends combinationally on out_ready and out_valid. There is no other combinational input-to-output path.
- When the pipe is full and out_ready = 0, in_ready = 0 in the same cycle.
- When out_ready returns to 1, an input is accepted in that same cycle.

## Configuration
- CSA_TREE_PIPE_CPA_EN defined: a registered OUT_W-bit carry-propagate adder stage follows the tree. out_result = out_sum + out_carry mod 2^OUT_W. Latency is LEVELS+1.
- Not defined: the out_result port and the adder stage are absent. Latency is LEVELS and the result is available only in redundant form.

## Structure
- Shared package csa_pkg holds:
  - function csa_levels(num_ops) returning LEVELS
  - function csa_out_w(width, num_ops) returning OUT_W
  - a typedef of the per-stage valid/tag record
- Sub-module csa_tree_level (parameters IN_VECS, OUT_W):
  - one compressor level plus its register stage
  - enable input driven by the global en
  - instantiated LEVELS times in a generate loop

## Test plan
- Max operands: WIDTH=8, NUM_OPS=8, all operands 0xFF, tag 0x5, out_ready=1 → out_valid exactly 3 cycles after transfer with CPA (2 without). out_sum+out_carry = out_result = 0x7F8 (11 bits). out_tag = 0x5.
- Streaming: 16 back-to-back vectors where operand k = k + n (n = 0..15) → one result per cycle, in order, each equal to 28 + 8n, with tags matching.
- Backpressure: hold out_ready=0 for 5 cycles with the pipe full → in_ready=0, outputs stable. Release → in_ready=1 in the same cycle, and no result is lost or duplicated.
- Bubbles: drive in_valid in the pattern 1,0,1,0 → out_valid shows the same 1,0,1,0 pattern after the pipeline latency, with correct sums.
- Reset mid-flight: assert rst for 1 cycle with 2 transactions in the pipe → out_valid=0 and all outputs 0 the next cycle, and the discarded results never appear.
- Randomised check: NUM_OPS=32, WIDTH=16, 1000 random vectors with random out_ready → (out_sum+out_carry) mod 2^21 equals the reference sum for every transfer.

Source files
------------

// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save reduction tree: derived-size helpers
// and the per-stage valid/tag record that travels alongside the data.
package csa_pkg;

  // Widest tag the stage record can carry; narrower tags are zero-extended.
  localparam int CSA_TAG_W_MAX = 32;

  typedef struct packed {
    logic                     valid;
    logic [CSA_TAG_W_MAX-1:0] tag;
  } csa_stage_t;

  // Number of 4:2 levels needed to bring num_ops vectors down to two.
  function automatic int csa_levels(input int num_ops);
    return $clog2(num_ops) - 32'sd1;
  endfunction

  // Result width wide enough that the total of all operands cannot overflow.
  function automatic int csa_out_w(input int width, input int num_ops);
    return width + $clog2(num_ops);
  endfunction

endpackage

// File: rtl/csa_tree_level.sv
// One registered level of the reduction tree: every group of four input
// vectors is compressed by a 4:2 compressor into a sum/carry pair, and the
// result plus the stage record is captured when the global enable is high.
module csa_tree_level
  import csa_pkg::*;
#(
  parameter int IN_VECS = 8,
  parameter int OUT_W   = 11
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [IN_VECS*OUT_W-1:0]     in_vec,
  input  csa_stage_t                   in_stage,
  output logic [(IN_VECS/2)*OUT_W-1:0] out_vec,
  output csa_stage_t                   out_stage
);

  localparam int GROUPS = IN_VECS / 32'sd4;

  logic [(IN_VECS/2)*OUT_W-1:0] comp_vec_s;
  logic [OUT_W-1:0]             a_s;
  logic [OUT_W-1:0]             b_s;
  logic [OUT_W-1:0]             c_s;
  logic [OUT_W-1:0]             d_s;
  logic [OUT_W-1:0]             s1_s;
  logic [OUT_W-1:0]             t_s;
  logic [(IN_VECS/2)*OUT_W-1:0] vec_r;
  csa_stage_t                   stage_r;

  // 4:2 compression per group: a first full-adder row on a,b,c whose carry
  // (weight +1) feeds a second row together with d; no ripple between bits.
  always_comb begin
    comp_vec_s = '0;
    a_s        = '0;
    b_s        = '0;
    c_s        = '0;
    d_s        = '0;
    s1_s       = '0;
    t_s        = '0;
    for (int g = 0; g < GROUPS; g++) begin
      a_s  = in_vec[(32'sd4*g)*OUT_W +: OUT_W];
      b_s  = in_vec[(32'sd4*g + 32'sd1)*OUT_W +: OUT_W];
      c_s  = in_vec[(32'sd4*g + 32'sd2)*OUT_W +: OUT_W];
      d_s  = in_vec[(32'sd4*g + 32'sd3)*OUT_W +: OUT_W];
      s1_s = a_s ^ b_s ^ c_s;
      t_s  = ((a_s & b_s) | (a_s & c_s) | (b_s & c_s)) << 1'b1;
      comp_vec_s[(32'sd2*g)*OUT_W +: OUT_W] = s1_s ^ d_s ^ t_s;
      comp_vec_s[(32'sd2*g + 32'sd1)*OUT_W +: OUT_W] =
        ((s1_s & d_s) | (s1_s & t_s) | (d_s & t_s)) << 1'b1;
    end
  end

  // Stage register: cleared by reset, advances only on the global enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_r   <= '0;
      stage_r <= '0;
    end else if (en) begin
      vec_r   <= comp_vec_s;
      stage_r <= in_stage;
    end
  end

  assign out_vec   = vec_r;
  assign out_stage = stage_r;

endmodule

// File: rtl/csa_tree_pipe.sv
// Pipelined multi-operand carry-save reduction tree with valid/ready on both
// sides and a single global stall enable. Optional feature macro:
//   CSA_TREE_PIPE_CPA_EN - adds a registered carry-propagate stage driving
//                          out_result; sum/carry are delayed to stay aligned.
module csa_tree_pipe
  import csa_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_OPS = 8,
  parameter int TAG_W   = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [NUM_OPS*WIDTH-1:0]              in_ops,
  input  logic [TAG_W-1:0]                      in_tag,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [csa_out_w(WIDTH, NUM_OPS)-1:0]  out_sum,
  output logic [csa_out_w(WIDTH, NUM_OPS)-1:0]  out_carry,
`ifdef CSA_TREE_PIPE_CPA_EN
  output logic [csa_out_w(WIDTH, NUM_OPS)-1:0]  out_result,
`endif
  output logic [TAG_W-1:0]                      out_tag
);

  localparam int LEVELS   = csa_levels(NUM_OPS);
  localparam int OUT_W    = csa_out_w(WIDTH, NUM_OPS);
  // Level outputs are packed back to back: NUM_OPS/2 + NUM_OPS/4 + ... + 2.
  localparam int BUS_VECS = NUM_OPS - 32'sd2;

  logic                      en_s;
  logic [NUM_OPS*OUT_W-1:0]  in_vec_s;
  csa_stage_t                in_stage_s;
  logic [BUS_VECS*OUT_W-1:0] lvl_bus_s;
  csa_stage_t                stage_s [1:LEVELS];
  logic [OUT_W-1:0]          red_sum_s;
  logic [OUT_W-1:0]          red_carry_s;
  csa_stage_t                final_stage_s;
  logic                      unused_tag_s;

  // One enable for the whole pipe: move whenever the output slot is free.
  assign en_s     = !out_valid || out_ready;
  assign in_ready = en_s && !rst;

  // Zero-extend every operand to the result width before reduction.
  always_comb begin
    in_vec_s = '0;
    for (int k = 0; k < NUM_OPS; k++) begin
      in_vec_s[k*OUT_W +: OUT_W] = OUT_W'(in_ops[k*WIDTH +: WIDTH]);
    end
  end

  assign in_stage_s.valid = in_valid;
  assign in_stage_s.tag   = CSA_TAG_W_MAX'(in_tag);

  for (genvar i = 1; i <= LEVELS; i++) begin : g_level
    localparam int IN_VECS  = NUM_OPS >> (i - 32'sd1);
    localparam int OUT_BASE = NUM_OPS - IN_VECS;
    localparam int IN_BASE  = OUT_BASE - IN_VECS;

    logic [IN_VECS*OUT_W-1:0] lvl_in_s;
    csa_stage_t               lvl_stage_s;

    if (i == 32'sd1) begin : g_first
      assign lvl_in_s    = in_vec_s;
      assign lvl_stage_s = in_stage_s;
    end else begin : g_next
      assign lvl_in_s    = lvl_bus_s[IN_BASE*OUT_W +: IN_VECS*OUT_W];
      assign lvl_stage_s = stage_s[i-32'sd1];
    end

    csa_tree_level #(
      .IN_VECS(IN_VECS),
      .OUT_W  (OUT_W)
    ) u_level (
      .clk      (clk),
      .rst      (rst),
      .en       (en_s),
      .in_vec   (lvl_in_s),
      .in_stage (lvl_stage_s),
      .out_vec  (lvl_bus_s[OUT_BASE*OUT_W +: (IN_VECS/32'sd2)*OUT_W]),
      .out_stage(stage_s[i])
    );
  end

  // The last level leaves exactly two vectors at the top of the bus.
  assign red_sum_s   = lvl_bus_s[(NUM_OPS-32'sd4)*OUT_W +: OUT_W];
  assign red_carry_s = lvl_bus_s[(NUM_OPS-32'sd3)*OUT_W +: OUT_W];

`ifdef CSA_TREE_PIPE_CPA_EN
  logic [OUT_W-1:0] sum_r;
  logic [OUT_W-1:0] carry_r;
  logic [OUT_W-1:0] result_r;
  csa_stage_t       cpa_stage_r;

  // Carry-propagate stage; sum/carry are re-registered to stay aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_r       <= '0;
      carry_r     <= '0;
      result_r    <= '0;
      cpa_stage_r <= '0;
    end else if (en_s) begin
      sum_r       <= red_sum_s;
      carry_r     <= red_carry_s;
      result_r    <= red_sum_s + red_carry_s;
      cpa_stage_r <= stage_s[LEVELS];
    end
  end

  assign out_sum       = sum_r;
  assign out_carry     = carry_r;
  assign out_result    = result_r;
  assign final_stage_s = cpa_stage_r;
`else
  assign out_sum       = red_sum_s;
  assign out_carry     = red_carry_s;
  assign final_stage_s = stage_s[LEVELS];
`endif

  assign out_valid    = final_stage_s.valid;
  assign out_tag      = final_stage_s.tag[TAG_W-1:0];
  assign unused_tag_s = ^final_stage_s.tag;

endmodule

// File: tb/tb_csa_tree_pipe.sv
// Bench for csa_tree_pipe: a small instance (8 x 8-bit) for directed
// latency/stream/stall/bubble/reset steps and a large one (32 x 16-bit) for
// a randomized run, both checked against an arithmetic scoreboard.
module tb_csa_tree_pipe;

  localparam int A_W  = 8;
  localparam int A_N  = 8;
  localparam int A_OW = 11;
  localparam int B_W  = 16;
  localparam int B_N  = 32;
  localparam int B_OW = 21;
  localparam int TW   = 4;
`ifdef CSA_TREE_PIPE_CPA_EN
  localparam int A_LAT = 3;
`else
  localparam int A_LAT = 2;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic              a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [A_N*A_W-1:0] a_in_ops;
  logic [TW-1:0]     a_in_tag, a_out_tag;
  logic [A_OW-1:0]   a_out_sum, a_out_carry;
  logic              b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [B_N*B_W-1:0] b_in_ops;
  logic [TW-1:0]     b_in_tag, b_out_tag;
  logic [B_OW-1:0]   b_out_sum, b_out_carry;
`ifdef CSA_TREE_PIPE_CPA_EN
  logic [A_OW-1:0]   a_out_result;
  logic [B_OW-1:0]   b_out_result;
`endif

  csa_tree_pipe #(.WIDTH(A_W), .NUM_OPS(A_N), .TAG_W(TW)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ops(a_in_ops), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_sum(a_out_sum), .out_carry(a_out_carry),
`ifdef CSA_TREE_PIPE_CPA_EN
    .out_result(a_out_result),
`endif
    .out_tag(a_out_tag)
  );

  csa_tree_pipe #(.WIDTH(B_W), .NUM_OPS(B_N), .TAG_W(TW)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ops(b_in_ops), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sum(b_out_sum), .out_carry(b_out_carry),
`ifdef CSA_TREE_PIPE_CPA_EN
    .out_result(b_out_result),
`endif
    .out_tag(b_out_tag)
  );

  typedef struct {
    logic [20:0] sum;
    logic [3:0]  tag;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int compared   = 0;
  int mismatched = 0;
  int a_ins = 0, a_outs = 0, b_ins = 0, b_outs = 0;
  logic a_seen, a_rdy;
  logic [A_OW-1:0] a_last_tot;
  logic [TW-1:0]   a_last_tag;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // Reference: plain integer sum of the operands, reduced modulo 2^21.
  function automatic logic [20:0] ref_sum(input logic [511:0] ops, input int n, input int w);
    longint s;
    logic [511:0] t;
    s = 0;
    for (int k = 0; k < n; k++) begin
      t = ops >> (k * w);
      s += (w == 8) ? longint'(t[7:0]) : longint'(t[15:0]);
    end
    return s[20:0];
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // One cycle on instance A: drive at negedge, evaluate both handshakes.
  task automatic a_cycle(input logic v, input logic [63:0] ops, input logic [3:0] tag,
                         input logic ordy, input logic r);
    exp_t e;
    logic [A_OW-1:0] tot;
    @(negedge clk);
    rst = r; a_in_valid = v; a_in_ops = ops; a_in_tag = tag; a_out_ready = ordy;
    #1;
    a_rdy  = a_in_ready;
    a_seen = a_out_valid && a_out_ready;
    if (a_seen) begin
      a_outs++;
      tot = a_out_sum + a_out_carry;
      a_last_tot = tot;
      a_last_tag = a_out_tag;
      compared++;
      assert (qa.size() != 0) else begin
        mismatched++;
        $error("FAIL a_spurious_out: observed result 0x%0h tag 0x%0h, expected none", tot, a_out_tag);
      end
      if (qa.size() != 0) begin
        e = qa.pop_front();
        check("a_total", 64'(tot), 64'(e.sum[A_OW-1:0]));
        check("a_tag", 64'(a_out_tag), 64'(e.tag));
`ifdef CSA_TREE_PIPE_CPA_EN
        check("a_result", 64'(a_out_result), 64'(e.sum[A_OW-1:0]));
`endif
      end
    end
    if (v && a_rdy && !r) begin
      qa.push_back('{sum: ref_sum(512'(ops), A_N, A_W), tag: tag});
      a_ins++;
    end
  endtask

  // One cycle on instance B, same scheme as instance A.
  task automatic b_cycle(input logic v, input logic [511:0] ops, input logic [3:0] tag,
                         input logic ordy);
    exp_t e;
    logic [B_OW-1:0] tot;
    @(negedge clk);
    rst = 1'b0; b_in_valid = v; b_in_ops = ops; b_in_tag = tag; b_out_ready = ordy;
    #1;
    if (b_out_valid && b_out_ready) begin
      b_outs++;
      tot = b_out_sum + b_out_carry;
      compared++;
      assert (qb.size() != 0) else begin
        mismatched++;
        $error("FAIL b_spurious_out: observed result 0x%0h, expected none", tot);
      end
      if (qb.size() != 0) begin
        e = qb.pop_front();
        check("b_total", 64'(tot), 64'(e.sum));
        check("b_tag", 64'(b_out_tag), 64'(e.tag));
`ifdef CSA_TREE_PIPE_CPA_EN
        check("b_result", 64'(b_out_result), 64'(e.sum));
`endif
      end
    end
    if (v && b_in_ready) begin
      qb.push_back('{sum: ref_sum(ops, B_N, B_W), tag: tag});
      b_ins++;
    end
  endtask

  initial begin
    int lat, outs0, ins0, cyc;
    logic [63:0]  ops;
    logic [511:0] bops;
    logic [A_OW-1:0] snap_sum, snap_carry;
    logic [TW-1:0]   snap_tag;

    rst = 1'b1;
    a_in_valid = 1'b0; a_in_ops = '0; a_in_tag = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_ops = '0; b_in_tag = '0; b_out_ready = 1'b0;

    // Reset state
    a_cycle(1'b0, 64'd0, 4'd0, 1'b1, 1'b1);
    a_cycle(1'b0, 64'd0, 4'd0, 1'b1, 1'b1);
    check("rst_in_ready", 64'(a_rdy), 64'd0);
    check("rst_out_valid", 64'(a_out_valid), 64'd0);
    check("rst_out_sum", 64'(a_out_sum), 64'd0);
    check("rst_out_carry", 64'(a_out_carry), 64'd0);
    check("rst_out_tag", 64'(a_out_tag), 64'd0);
    check("rst_b_out_valid", 64'(b_out_valid), 64'd0);
`ifdef CSA_TREE_PIPE_CPA_EN
    check("rst_out_result", 64'(a_out_result), 64'd0);
`endif
    a_cycle(1'b0, 64'd0, 4'd0, 1'b1, 1'b0);
    check("post_rst_in_ready", 64'(a_rdy), 64'd1);

    // Max operands: latency, total and tag
    a_cycle(1'b1, {8{8'hFF}}, 4'h5, 1'b1, 1'b0);
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      a_cycle(1'b0, 64'd0, 4'd0, 1'b1, 1'b0);
      if (a_seen && lat < 0) begin
        lat = i;
        check("max_total", 64'(a_last_tot), 64'h7F8);
        check("max_tag", 64'(a_last_tag), 64'h5);
      end
    end
    check("max_latency", 64'(lat), 64'(A_LAT));

    // Streaming: 16 back-to-back vectors, operand k = k + n
    for (int i = 0; i < 16 + A_LAT; i++) begin
      ops = '0;
      for (int k = 0; k < A_N; k++) ops[k*A_W +: A_W] = 8'(k + i);
      a_cycle(i < 16, ops, 4'(i), 1'b1, 1'b0);
      check($sformatf("stream_valid_%0d", i), 64'(a_seen), 64'(i >= A_LAT));
    end
    check("stream_drained", 64'(qa.size()), 64'd0);

    // Backpressure: fill, stall 5 cycles, release
    outs0 = a_outs; ins0 = a_ins;
    for (int i = 0; i < 3; i++) a_cycle(1'b1, rnd64(), 4'(i + 1), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      a_cycle(1'b1, rnd64(), 4'hA, 1'b0, 1'b0);
      check("bp_in_ready", 64'(a_rdy), 64'd0);
      check("bp_out_valid", 64'(a_out_valid), 64'd1);
      if (i == 0) begin
        snap_sum = a_out_sum; snap_carry = a_out_carry; snap_tag = a_out_tag;
      end else begin
        check("bp_hold_sum", 64'(a_out_sum), 64'(snap_sum));
        check("bp_hold_carry", 64'(a_out_carry), 64'(snap_carry));
        check("bp_hold_tag", 64'(a_out_tag), 64'(snap_tag));
      end
    end
    a_cycle(1'b1, rnd64(), 4'hB, 1'b1, 1'b0);
    check("bp_release_ready", 64'(a_rdy), 64'd1);
    for (int i = 0; i < 8; i++) a_cycle(1'b0, 64'd0, 4'd0, 1'b1, 1'b0);
    check("bp_drained", 64'(qa.size()), 64'd0);
    check("bp_count", 64'(a_outs - outs0), 64'(a_ins - ins0));

    // Bubbles: in_valid 1,0,1,0
    for (int i = 0; i < 4 + A_LAT + 2; i++) begin
      a_cycle((i < 4) && (i % 2 == 0), rnd64(), 4'(i + 6), 1'b1, 1'b0);
      check($sformatf("bubble_valid_%0d", i), 64'(a_seen),
            64'((i >= A_LAT) && (i - A_LAT < 4) && ((i - A_LAT) % 2 == 0)));
    end

    // Reset with two transactions in flight
    outs0 = a_outs;
    a_cycle(1'b1, rnd64(), 4'h3, 1'b0, 1'b0);
    a_cycle(1'b1, rnd64(), 4'h4, 1'b0, 1'b0);
    a_cycle(1'b0, 64'd0, 4'd0, 1'b0, 1'b1);
    qa.delete();
    a_cycle(1'b0, 64'd0, 4'd0, 1'b1, 1'b0);
    check("midrst_out_valid", 64'(a_out_valid), 64'd0);
    check("midrst_out_sum", 64'(a_out_sum), 64'd0);
    check("midrst_out_carry", 64'(a_out_carry), 64'd0);
    check("midrst_out_tag", 64'(a_out_tag), 64'd0);
`ifdef CSA_TREE_PIPE_CPA_EN
    check("midrst_out_result", 64'(a_out_result), 64'd0);
`endif
    for (int i = 0; i < 6; i++) a_cycle(1'b0, 64'd0, 4'd0, 1'b1, 1'b0);
    check("midrst_no_ghost", 64'(a_outs - outs0), 64'd0);

    // Randomized run on the 32 x 16-bit instance
    a_in_valid = 1'b0;
    cyc = 0;
    while (b_ins < 1000 && cyc < 6000) begin
      for (int j = 0; j < 16; j++) bops[j*32 +: 32] = $urandom;
      b_cycle($urandom_range(0, 3) != 0, bops, 4'($urandom), $urandom_range(0, 3) != 0);
      cyc++;
    end
    cyc = 0;
    while (qb.size() != 0 && cyc < 100) begin
      b_cycle(1'b0, '0, 4'd0, 1'b1);
      cyc++;
    end
    check("rand_accepted", 64'(b_ins), 64'd1000);
    check("rand_drained", 64'(qb.size()), 64'd0);
    check("rand_outputs", 64'(b_outs), 64'd1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
